toggle_rr_arbiter: RTL and testbench
====================================

TOGGLE_RR_ARBITER -- requirements
Module: toggle_rr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter IDXW, default 2, SHALL set the owner index width and SHALL satisfy 2**IDXW >= NREQ.
REQ-003 Port clk1, input, 1: single clock; all state SHALL update on the rising edge only.
REQ-004 Port clr, input, 1: reset, synchronous and active-high.
REQ-005 Port req, input, NREQ: per-requester level request for the shared toggle resource.
REQ-006 Port gnt, output, NREQ: registered one-hot grant; all zero when no owner.
REQ-007 Port owner, output, IDXW: index of the current or most recent grantee.
REQ-008 Port tog, output, 1: shared 1-bit toggle counter value.
REQ-009 Port done, output, NREQ: one-cycle pulse on the owner's bit when its grant completes normally.
REQ-010 Port abort, output, 1: one-cycle pulse when a grant ends early.
REQ-011 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, RELEASE.
REQ-013 In IDLE with req != 0, the arbiter SHALL pick the first set req bit searching upward from (last_owner+1) mod NREQ, wrapping around, and SHALL enter GRANT next cycle.
REQ-014 In IDLE with req == 0, it SHALL stay in IDLE with gnt, tog, done and abort all 0.
REQ-015 gnt and owner SHALL be valid on the first GRANT cycle, one cycle after req is sampled in IDLE.
REQ-016 tog SHALL be 0 on entry to GRANT and SHALL toggle every GRANT cycle, so GRANT lasts exactly 2 cycles (tog = 0, then 1).
REQ-017 In GRANT with tog == 1 and the owner's req still high, the FSM SHALL go to RELEASE and assert done[owner] for that RELEASE cycle.
REQ-018 If the owner's req is low during any GRANT cycle, the FSM SHALL go to RELEASE next cycle with abort = 1 and done = 0.
REQ-019 In RELEASE, gnt SHALL be 0 and tog SHALL be 0; the FSM SHALL return to IDLE unconditionally after one cycle.
REQ-020 last_owner SHALL update to owner on entry to RELEASE, on both normal completion and abort.
REQ-021 Requests from non-owners during GRANT or RELEASE SHALL be ignored until the next IDLE cycle.
REQ-022 With one requester held high, gnt SHALL cycle as high 2, low 2 (GRANT, GRANT, RELEASE, IDLE).
REQ-023 done and abort SHALL never be high in the same cycle; gnt SHALL never have more than one bit set.

Reset
REQ-024 When clr is high at a clk1 edge, the next state SHALL be IDLE with gnt = 0, tog = 0, done = 0, abort = 0, busy = 0, owner = 0.
REQ-025 On reset, last_owner SHALL be set to NREQ-1, so requester 0 has top priority after reset.
REQ-026 clr SHALL take priority over every other event, including reset asserted mid-GRANT, and SHALL emit no done or abort pulse.

Structure
REQ-027 The state encoding (IDLE = 0, GRANT = 1, RELEASE = 2) and the default NREQ/IDXW values SHALL live in a shared package, toggle_arb_pkg.
REQ-028 The shared toggle SHALL be one instance of sub-module toggle_cell, which has clk1, a synchronous clear, an enable and a 1-bit count.
REQ-029 The toggle_cell enable SHALL be high in GRANT; its clear SHALL be driven by clr OR NOT(state == GRANT).
REQ-030 The round-robin search SHALL be combinational from req and last_owner; every output SHALL come straight from a register.

Verification
REQ-031 Reset: clr = 1 for 2 cycles with req = 4'b1111 -> gnt = 0, busy = 0; after release, first gnt = 4'b0001 one cycle later.
REQ-032 Single requester: req = 4'b0100 held -> gnt = 0100 for 2 cycles, tog = 0 then 1, done = 0100 in the RELEASE cycle; the pattern repeats every 4 cycles.
REQ-033 Round robin: req = 4'b1111 held -> grant order 0001, 0010, 0100, 1000, 0001 (wrap), each grant 2 cycles.
REQ-034 Abort: req = 0010 granted, req dropped on the first GRANT cycle -> RELEASE next cycle with abort = 1, done = 0; the next grant search starts from index 2.
REQ-035 Reset mid-operation: clr = 1 during the second GRANT cycle -> next cycle IDLE, tog = 0, no done or abort; with req = 1000, the next grant goes to requester 3 (search starts from 0).
REQ-036 Late request: req = 0001 granted, req[2] raised in GRANT -> ignored until IDLE, then gnt = 0100.

Source files
------------

// File: rtl/toggle_arb_pkg.sv
// Shared definitions for the toggle round-robin arbiter: state encoding and
// default sizing.
package toggle_arb_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned IDXW_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/toggle_cell.sv
// One-bit toggle counter with synchronous clear (priority) and enable.
module toggle_cell (
  input  logic clk1,
  input  logic clear_i,
  input  logic en_i,
  output logic count_o
);

  logic count_q;

  always_ff @(posedge clk1) begin
    if (clear_i) begin
      count_q <= 1'b0;
    end else if (en_i) begin
      count_q <= ~count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/toggle_rr_arbiter.sv
// Round-robin arbiter granting a shared toggle resource for two cycles per
// grant; a grantee dropping its request ends the grant early with an abort.
module toggle_rr_arbiter
  import toggle_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IDXW = IDXW_DEF
) (
  input  logic            clk1,
  input  logic            clr,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] owner,
  output logic            tog,
  output logic [NREQ-1:0] done,
  output logic            abort,
  output logic            busy
);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            abort_q, abort_d;
  logic            busy_q;

  logic [IDXW-1:0] pick_c;
  logic            found_c;
  logic            owner_req_c;
  logic            tog_c;

  // Round-robin search: first set request after last_q, wrapping.
  always_comb begin : rr_search
    int unsigned sum;
    logic [IDXW-1:0] idx;
    sum     = 0;
    idx     = '0;
    pick_c  = last_q;
    found_c = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      sum = 32'(last_q) + i;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      idx = IDXW'(sum);
      if (!found_c && req[idx]) begin
        found_c = 1'b1;
        pick_c  = idx;
      end
    end
  end

  assign owner_req_c = req[owner_q];

  always_comb begin : next_state
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    done_d  = '0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = GRANT;
          owner_d = pick_c;
        end
      end
      GRANT: begin
        // A dropped request wins over normal completion on the last cycle.
        if (!owner_req_c) begin
          state_d = RELEASE;
          abort_d = 1'b1;
          last_d  = owner_q;
        end else if (tog_c) begin
          state_d = RELEASE;
          done_d  = NREQ'(1) << owner_q;
          last_d  = owner_q;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == GRANT) ? (NREQ'(1) << owner_d) : '0;
  end

  always_ff @(posedge clk1) begin
    if (clr) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDXW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Cleared against the next state so tog is 0 on GRANT entry and in RELEASE.
  toggle_cell u_toggle (
    .clk1    (clk1),
    .clear_i (clr | (state_d != GRANT)),
    .en_i    (state_q == GRANT),
    .count_o (tog_c)
  );

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign tog   = tog_c;
  assign done  = done_q;
  assign abort = abort_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_toggle_rr_arbiter.sv
// Scoreboard bench for toggle_rr_arbiter: a phase-counting reference model
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_toggle_rr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDXW = 2;

  logic            clk1 = 1'b0;
  logic            clr;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] owner;
  logic            tog;
  logic [NREQ-1:0] done;
  logic            abort;
  logic            busy;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] owner;
    logic            tog;
    logic [NREQ-1:0] done;
    logic            abort;
    logic            busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: phase 0 idle, 1/2 first/second grant cycle, 3 release.
  int m_phase = 0;
  int m_owner = 0;
  int m_last  = NREQ - 1;

  toggle_rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
    .clk1  (clk1),
    .clr   (clr),
    .req   (req),
    .gnt   (gnt),
    .owner (owner),
    .tog   (tog),
    .done  (done),
    .abort (abort),
    .busy  (busy)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model(input logic c, input logic [NREQ-1:0] r);
    exp_t e;
    e.done  = '0;
    e.abort = 1'b0;
    if (c) begin
      m_phase = 0;
      m_owner = 0;
      m_last  = NREQ - 1;
    end else begin
      case (m_phase)
        0: begin
          if (r != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
              int cand;
              cand = (m_last + k) % NREQ;
              if (r[2'(cand)]) begin
                m_owner = cand;
                break;
              end
            end
            m_phase = 1;
          end
        end
        1, 2: begin
          if (!r[2'(m_owner)]) begin
            m_phase = 3;
            e.abort = 1'b1;
            m_last  = m_owner;
          end else if (m_phase == 2) begin
            m_phase = 3;
            e.done  = 4'(1) << m_owner;
            m_last  = m_owner;
          end else begin
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
    e.gnt   = (m_phase == 1 || m_phase == 2) ? (4'(1) << m_owner) : 4'(0);
    e.owner = 2'(m_owner);
    e.tog   = (m_phase == 2);
    e.busy  = (m_phase != 0);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic c, input logic [NREQ-1:0] r);
    @(negedge clk1);
    #1;
    clr = c;
    req = r;
    model(c, r);
  endtask

  always @(negedge clk1) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt",   32'(gnt),   32'(e.gnt));
      check("owner", 32'(owner), 32'(e.owner));
      check("tog",   32'(tog),   32'(e.tog));
      check("done",  32'(done),  32'(e.done));
      check("abort", 32'(abort), 32'(e.abort));
      check("busy",  32'(busy),  32'(e.busy));
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
      check("done_abort_excl", 32'((done != '0) && abort), 32'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] rq;
    clr = 1'b1;
    req = '0;
    // Reset with all requesting, then round robin with wrap.
    repeat (2) step(1'b1, 4'b1111);
    repeat (18) step(1'b0, 4'b1111);
    // Single requester repeating every 4 cycles.
    step(1'b1, 4'b0000);
    repeat (12) step(1'b0, 4'b0100);
    // Abort on first grant cycle, next search from index 2.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    repeat (6) step(1'b0, 4'b1111);
    // Reset during second grant cycle, then requester 3.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0001);
    step(1'b1, 4'b0001);
    repeat (4) step(1'b0, 4'b1000);
    // Late request ignored until idle.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0001);
    repeat (6) step(1'b0, 4'b0101);
    // Randomized traffic with occasional resets.
    rq = 4'($urandom);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      step(($urandom_range(0, 31) == 0), rq);
    end
    @(negedge clk1);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
